// File: rtl/signed_product_accumulator.sv
// signed_product_accumulator
//   Registered consumer for the 4x4 Baugh-Wooley multiplier. Accumulates a
//   run of signed 8-bit products into an ACC_W-bit signed sum. The finished
//   sum is presented on a valid/ready handshake with a term count and a
//   sticky signed-overflow flag.
//
//   Optional feature macro: SIGNED_ACC_SATURATE_EN
//     defined   - overflowing additions clamp to the signed max/min
//     undefined - overflowing additions wrap modulo 2^ACC_W
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     prod       in   [7:0] signed product (two's complement)
//     prod_valid in   prod is valid this cycle
//     prod_last  in   prod is the final term of the current sum
//     prod_ready out  block can accept prod this cycle (registered)
//     acc_out    out  [ACC_W-1:0] signed accumulator value
//     acc_valid  out  acc_out holds a completed sum (registered)
//     acc_ready  in   downstream accepts the completed sum
//     term_count out  [CNT_W-1:0] terms in the current sum, saturating
//     ovf        out  sticky signed overflow for the current sum
module signed_product_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    input  logic             prod_last,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [CNT_W-1:0] term_count,
    output logic             ovf
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t state;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] next_acc;
    logic             add_ovf;
    logic             accept;
    logic             drain;

    assign prod_ext = ACC_W'(signed'(prod));
    assign sum      = acc_out + prod_ext;

    // Overflow only when both operands share a sign and the result flips it.
    assign add_ovf  = (acc_out[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_out[ACC_W-1]);

`ifdef SIGNED_ACC_SATURATE_EN
    // Negative operands overflow toward the minimum, positive toward the maximum.
    always_comb begin
        next_acc = sum;
        if (add_ovf) begin
            next_acc = acc_out[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign next_acc = sum;
`endif

    assign accept = prod_valid & prod_ready;
    assign drain  = acc_valid & acc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            acc_out    <= '0;
            term_count <= '0;
            ovf        <= 1'b0;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_out <= next_acc;
                        if (term_count != '1) begin
                            term_count <= term_count + CNT_W'(1);
                        end
                        ovf <= ovf | add_ovf;
                        if (prod_last) begin
                            state      <= HOLD;
                            acc_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        state      <= ACCUM;
                        acc_out    <= '0;
                        term_count <= '0;
                        ovf        <= 1'b0;
                        acc_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Testbench for signed_product_accumulator. Three instances share one
// stimulus stream: (ACC_W=16,CNT_W=4), (ACC_W=8,CNT_W=4), (ACC_W=16,CNT_W=2).
// Each is compared against an integer-arithmetic reference model.
module tb_signed_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  prod = '0;
    logic        prod_valid = 1'b0;
    logic        prod_last = 1'b0;
    logic        acc_ready = 1'b0;

    logic [15:0] acc_a;
    logic [7:0]  acc_b;
    logic [15:0] acc_c;
    logic [3:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    logic [2:0]  pr, av, ov;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    signed_product_accumulator #(.ACC_W(16), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(pr[0]), .acc_out(acc_a),
        .acc_valid(av[0]), .acc_ready(acc_ready), .term_count(cnt_a), .ovf(ov[0]));

    signed_product_accumulator #(.ACC_W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(pr[1]), .acc_out(acc_b),
        .acc_valid(av[1]), .acc_ready(acc_ready), .term_count(cnt_b), .ovf(ov[1]));

    signed_product_accumulator #(.ACC_W(16), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(pr[2]), .acc_out(acc_c),
        .acc_valid(av[2]), .acc_ready(acc_ready), .term_count(cnt_c), .ovf(ov[2]));

    // Reference model state
    int     w_acc[3] = '{16, 8, 16};
    int     w_cnt[3] = '{4, 4, 2};
    longint m_sum[3];
    int     m_cnt[3];
    bit     m_ovf[3];
    bit     m_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_acc(input int i);
        case (i)
            0: return 64'(acc_a);
            1: return 64'(acc_b);
            default: return 64'(acc_c);
        endcase
    endfunction

    function automatic logic [63:0] get_cnt(input int i);
        case (i)
            0: return 64'(cnt_a);
            1: return 64'(cnt_b);
            default: return 64'(cnt_c);
        endcase
    endfunction

    function automatic logic [63:0] mask_w(input longint v, input int w);
        longint m;
        m = (longint'(1) <<< w) - 1;
        return 64'(v & m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_hold = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s acc[%0d]", tag, i), get_acc(i), mask_w(m_sum[i], w_acc[i]));
            check($sformatf("%s cnt[%0d]", tag, i), get_cnt(i), 64'(m_cnt[i]));
            check($sformatf("%s ovf[%0d]", tag, i), 64'(ov[i]), 64'(m_ovf[i]));
            check($sformatf("%s prod_ready[%0d]", tag, i), 64'(pr[i]), 64'(!m_hold));
            check($sformatf("%s acc_valid[%0d]", tag, i), 64'(av[i]), 64'(m_hold));
        end
    endtask

    // Advance one clock edge, updating the model from inputs held across it.
    task automatic tick();
        bit     do_acc, do_drain, is_last;
        longint p, full, vmax, vmin, modv;
        do_acc   = prod_valid && !m_hold;
        do_drain = m_hold && acc_ready;
        is_last  = prod_last;
        p        = longint'($signed(prod));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (do_acc) begin
                full = m_sum[i] + p;
                vmax = (longint'(1) <<< (w_acc[i] - 1)) - 1;
                vmin = -(longint'(1) <<< (w_acc[i] - 1));
                modv = longint'(1) <<< w_acc[i];
                if (full > vmax || full < vmin) begin
                    m_ovf[i] = 1'b1;
`ifdef SIGNED_ACC_SATURATE_EN
                    full = (full > vmax) ? vmax : vmin;
`else
                    full = (full > vmax) ? full - modv : full + modv;
`endif
                end
                m_sum[i] = full;
                if (m_cnt[i] < (1 << w_cnt[i]) - 1) m_cnt[i]++;
            end
            if (do_drain) begin
                m_sum[i] = 0;
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end
        end
        if (do_acc && is_last) m_hold = 1'b1;
        if (do_drain) m_hold = 1'b0;
    endtask

    task automatic beat(input logic [7:0] p, input bit last);
        prod       = p;
        prod_valid = 1'b1;
        prod_last  = last;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    // Pulse rst between clock edges and check outputs before any edge occurs.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain_now();
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // 1: reset
        async_reset("reset");
        check("reset acc16 const", get_acc(0), 64'h0);

        // 2: basic sum 5 + (-3) + 7 = 9
        beat(8'h05, 1'b0);
        check_all("basic b1");
        beat(8'hFD, 1'b0);
        check_all("basic b2");
        beat(8'h07, 1'b1);
        check_all("basic done");
        check("basic acc const", get_acc(0), 64'h0009);
        check("basic cnt const", get_cnt(0), 64'd3);

        // 3: backpressure with upstream holding 0x11
        prod = 8'h11;
        prod_valid = 1'b1;
        acc_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("bp hold");
            check("bp hold acc const", get_acc(0), 64'h0009);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check_all("bp drain");
        check("bp drain ready", 64'(pr[0]), 64'd1);
        tick();
        check_all("bp accept");
        check("bp accept acc const", get_acc(0), 64'h0011);
        prod_valid = 1'b0;
        async_reset("reset2");

        // 4: positive overflow (8-bit instance)
        beat(8'h40, 1'b0);
        beat(8'h40, 1'b1);
        check_all("pos ovf");
`ifdef SIGNED_ACC_SATURATE_EN
        check("pos ovf acc8 const", get_acc(1), 64'h7F);
`else
        check("pos ovf acc8 const", get_acc(1), 64'h80);
`endif
        check("pos ovf flag const", 64'(ov[1]), 64'd1);
        drain_now();
        check_all("pos ovf drained");

        // 5: negative overflow on the third beat only
        beat(8'hC8, 1'b0);
        beat(8'hC8, 1'b0);
        check_all("neg ovf b2");
        check("neg ovf b2 flag", 64'(ov[1]), 64'd0);
        check("neg ovf b2 acc8", get_acc(1), 64'h90);
        beat(8'hC8, 1'b1);
        check_all("neg ovf done");
`ifdef SIGNED_ACC_SATURATE_EN
        check("neg ovf acc8 const", get_acc(1), 64'h80);
`else
        check("neg ovf acc8 const", get_acc(1), 64'h58);
`endif
        drain_now();

        // 6a: reset mid-sum, then a clean sum
        beat(8'h03, 1'b0);
        beat(8'h03, 1'b0);
        async_reset("mid reset");
        beat(8'h02, 1'b1);
        check_all("after mid reset");
        check("after mid reset acc", get_acc(0), 64'h0002);
        drain_now();

        // 6b: counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) beat(8'h01, k == 4);
        check_all("cnt sat");
        check("cnt sat cnt2", get_cnt(2), 64'd3);
        check("cnt sat acc", get_acc(2), 64'h0005);
        check("cnt sat cnt4", get_cnt(0), 64'd5);
        drain_now();

        // prod_last without prod_valid is ignored; acc_ready in ACCUM is ignored
        prod_last = 1'b1;
        acc_ready = 1'b1;
        prod = 8'h7F;
        tick();
        prod_last = 1'b0;
        acc_ready = 1'b0;
        check_all("idle last");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            prod       = 8'($urandom);
            prod_valid = ($urandom_range(0, 3) != 0);
            prod_last  = ($urandom_range(0, 5) == 0);
            acc_ready  = ($urandom_range(0, 2) == 0);
            tick();
            check_all("random");
            if ($urandom_range(0, 99) == 0) async_reset("random reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/signed_product_accumulator.md
Name: signed_product_accumulator

Overview:
- Sequential stage directly downstream of the team's 4x4 Baugh-Wooley signed multiplier.
- Consumes its 8-bit two's-complement product and accumulates a run of products into a wider signed sum (dot-product / MAC use).
- Presents the finished sum on a valid/ready output handshake.
- Gives the combinational multiplier a registered consumer with backpressure, term counting and overflow reporting.

Parameters:
ACC_W, 16, accumulator and result width in bits; legal range >= 8.
CNT_W, 4, width of the term counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
prod  input  8  signed product from the multiplier (two's complement).
prod_valid  input  1  prod is valid this cycle.
prod_last  input  1  qualifies prod as the final term of the current sum.
prod_ready  output  1  block can accept prod this cycle.
acc_out  output  ACC_W  accumulator value, signed.
acc_valid  output  1  acc_out holds a completed sum.
acc_ready  input  1  downstream accepts the completed sum.
term_count  output  CNT_W  terms accumulated into the current sum.
ovf  output  1  sticky signed-overflow flag for the current sum.

Behaviour:
- Reset: asserting rst immediately forces the following values, regardless of clk and including mid-sum:
  - state = ACCUM
  - acc_out = 0, term_count = 0, ovf = 0
  - acc_valid = 0, prod_ready = 1
- No other output is changed by rst.
- Two-state FSM: ACCUM and HOLD.
- ACCUM state:
  - prod_ready = 1, acc_valid = 0.
  - acc_out shows the running partial sum.
- Accept occurs when prod_valid & prod_ready. On accept, at the next rising edge:
  - acc_out <= acc_out + sign_extend(prod) to ACC_W.
  - term_count increments, saturating at 2^CNT_W-1 (no wrap).
  - ovf sets if the addition overflows (both operands same sign, result sign differs). ovf is sticky until the sum is drained.
  - If prod_last is also set: state -> HOLD and acc_valid = 1 in the same edge.
  - Latency: the result is visible the cycle after the last beat.
- prod_last without prod_valid is ignored.
- A single-beat sum (first beat carries prod_last) is legal.
- HOLD state:
  - prod_ready = 0, acc_valid = 1.
  - acc_out, term_count and ovf are frozen.
  - prod_valid is ignored; no data is lost, because upstream must hold its data until accepted.
- Drain occurs when acc_valid & acc_ready. At the next edge:
  - acc_out = 0, term_count = 0, ovf = 0
  - acc_valid = 0
  - state -> ACCUM
- The earliest next accept is the cycle after drain, so there is one bubble per sum.
- acc_ready asserted in ACCUM has no effect.
- Outputs are registered. prod_ready is a pure function of the state register, with no combinational path from acc_ready.

Optional Feature:
- Macro: SIGNED_ACC_SATURATE_EN.
- Defined: on overflow, acc_out clamps to the signed maximum (2^(ACC_W-1)-1) for positive overflow or the signed minimum (-2^(ACC_W-1)) for negative overflow. ovf still sets. Later terms add to the clamped value.
- Undefined: acc_out wraps modulo 2^ACC_W. ovf still sets.

Test Plan:
1. Reset: pulse rst between clock edges, ACC_W=16 -> immediately acc_out=0x0000, acc_valid=0, prod_ready=1, term_count=0, ovf=0.
2. Basic sum: prod 0x05, 0xFD, 0x07 (last) on consecutive cycles -> cycle after third beat: acc_out=0x0009, term_count=3, acc_valid=1, prod_ready=0, ovf=0.
3. Backpressure: after test 2, hold acc_ready=0 for 5 cycles with prod_valid=1, prod=0x11 -> acc_out stays 0x0009 and prod is not accepted. Then pulse acc_ready for 1 cycle -> next cycle acc_out=0, acc_valid=0, prod_ready=1, and 0x11 is accepted on the following edge.
4. Positive overflow, ACC_W=8: 0x40, 0x40 (last) -> wrap build: acc_out=0x80, ovf=1; SIGNED_ACC_SATURATE_EN build: acc_out=0x7F, ovf=1.
5. Negative overflow, ACC_W=8: 0xC8, 0xC8, 0xC8 (last) -> wrap build: acc_out=0x58, ovf=1; saturate build: acc_out=0x80, ovf=1. ovf is 0 after the second beat (partial sum 0x90).
6. Reset mid-sum and counter saturation:
   - 2 beats of 0x03, then assert rst asynchronously -> acc_out=0 immediately; the next sum starts clean.
   - Separately, with CNT_W=2, send 5 beats of 0x01 (last on the 5th) -> term_count=3, acc_out=0x0005.
